// File: rtl/ising_energy_monitor_pkg.sv
// Shared definitions for the Ising energy monitor.
// Contents:
//   - mon_state_t : monitor FSM states IDLE/SETTLE/EVAL/DONE
//   - cw()        : safe clog2 for widths (never returns 0)
//   - num_pairs() : N*(N-1)/2 spin pairs
//   - bias_of()   : offset subtracted from a weight code to get J
//   - score_width(): signed width that holds the largest possible |score|
//   - pair_index(): linear index of pair (i,j), i<j, i-major then j ascending
package ising_energy_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EVAL,
        DONE
    } mon_state_t;

    function automatic int unsigned cw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned num_pairs(input int unsigned n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int unsigned bias_of(input int unsigned nw);
        return (nw - 1) / 2;
    endfunction

    function automatic int unsigned score_width(input int unsigned n, input int unsigned nw);
        return $clog2(num_pairs(n) * bias_of(nw) + 1) + 1;
    endfunction

    // Pairs before row i: sum_{k<i}(n-1-k) = i*(2n-i-1)/2; then offset within row.
    function automatic int unsigned pair_index(input int unsigned i, input int unsigned j,
                                               input int unsigned n);
        return i * (2 * n - i - 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/ising_energy_monitor_pair_iter.sv
// ising_pair_iter: walks all spin pairs (i,j), i<j, in i-major order.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   load      : restart at pair (0,1), index 0
//   advance   : step to the next pair (holds on the last pair)
//   i, j      : current pair spin indices
//   p         : current linear pair index
//   last      : current pair is the final one (p == NUM_PAIRS-1)
module ising_pair_iter
    import ising_energy_monitor_pkg::*;
#(
    parameter  int unsigned N         = 6,
    localparam int unsigned NUM_PAIRS = num_pairs(N),
    localparam int unsigned IW        = cw(N),
    localparam int unsigned PW        = cw(NUM_PAIRS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic          advance,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [PW-1:0] p,
    output logic          last
);

    always_comb begin
        last = (p == PW'(pair_index(N - 2, N - 1, N)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i <= '0;
            j <= IW'(1);
            p <= '0;
        end else if (load) begin
            i <= '0;
            j <= IW'(1);
            p <= '0;
        end else if (advance && !last) begin
            p <= p + 1'b1;
            if (j == IW'(N - 1)) begin
                i <= i + 1'b1;
                j <= i + IW'(2);
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ising_energy_monitor.sv
// ising_energy_monitor: waits for the oscillator phases to settle, snapshots
// them with the coupling weights, scores sum(J_ij * s_i * s_j) one pair per
// cycle, presents the result over valid/ready and tracks the best result.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   weights        : packed coupling codes, pair p at [p*WW +: WW], J = code - BIAS
//   phase          : spin phases (1 -> +1, 0 -> -1)
//   start          : begin a settle/evaluate run (IDLE only)
//   clear_best     : invalidate best record (a same-edge best update wins)
//   busy           : high in SETTLE and EVAL
//   result_valid/result_ready : result handshake
//   result_score/result_phase/result_timeout : last result
//   best_valid/best_score/best_phase : best result since reset/clear
module ising_energy_monitor
    import ising_energy_monitor_pkg::*;
#(
    parameter  int unsigned N             = 6,
    parameter  int unsigned NUM_WEIGHTS   = 3,
    parameter  int unsigned STABLE_CYCLES = 8,
    parameter  int unsigned TIMEOUT       = 1024,
    localparam int unsigned NUM_PAIRS     = num_pairs(N),
    localparam int unsigned WW            = cw(NUM_WEIGHTS),
    localparam int unsigned BIAS          = bias_of(NUM_WEIGHTS),
    localparam int unsigned SW            = score_width(N, NUM_WEIGHTS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_PAIRS*WW-1:0] weights,
    input  logic [N-1:0]            phase,
    input  logic                    start,
    input  logic                    clear_best,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic signed [SW-1:0]    result_score,
    output logic [N-1:0]            result_phase,
    output logic                    result_timeout,
    output logic                    best_valid,
    output logic signed [SW-1:0]    best_score,
    output logic [N-1:0]            best_phase
);

    localparam int unsigned IW  = cw(N);
    localparam int unsigned PW  = cw(NUM_PAIRS);
    localparam int unsigned STW = cw(STABLE_CYCLES + 1);
    localparam int unsigned TOW = cw(TIMEOUT + 1);
    localparam logic signed [WW+1:0] BIAS_V = (WW + 2)'(BIAS);

    mon_state_t state, state_nxt;

    logic [N-1:0]            prev;
    logic [STW-1:0]          stable_cnt;
    logic [TOW-1:0]          settle_cnt;
    logic [N-1:0]            snap_phase;
    logic [NUM_PAIRS*WW-1:0] snap_weights;
    logic                    snap_timeout;
    logic signed [SW-1:0]    acc;

    logic [IW-1:0]           pi;
    logic [IW-1:0]           pj;
    logic [PW-1:0]           pp;
    logic                    plast;

    logic                    stable_hit;
    logic                    timeout_hit;
    logic                    go_eval;
    logic                    iter_load;
    logic [WW-1:0]           code;
    logic signed [WW+1:0]    jv;
    logic signed [WW+1:0]    tv;
    logic signed [SW-1:0]    term;
    logic signed [SW-1:0]    score_final;

    ising_pair_iter #(.N(N)) u_iter (
        .clk     (clk),
        .rstn    (rstn),
        .load    (iter_load),
        .advance (state == EVAL),
        .i       (pi),
        .j       (pj),
        .p       (pp),
        .last    (plast)
    );

    // Both hit tests look at the value the counter takes on this edge, so the
    // EVAL transition happens on the very edge the threshold is reached.
    always_comb begin
        stable_hit  = (phase == prev) &&
                      (32'(stable_cnt) + 32'd1 == 32'(STABLE_CYCLES));
        timeout_hit = (32'(settle_cnt) + 32'd1 >= 32'(TIMEOUT));
        go_eval     = stable_hit || timeout_hit;
        iter_load   = (state == SETTLE) && go_eval;
    end

    // s_i*s_j is +1 when the phase bits agree, -1 otherwise.
    always_comb begin
        code        = snap_weights[pp*WW +: WW];
        jv          = $signed({2'b00, code}) - BIAS_V;
        tv          = (snap_phase[pi] == snap_phase[pj]) ? jv : -jv;
        term        = SW'(tv);
        score_final = acc + term;
    end

    always_comb begin
        busy = (state == SETTLE) || (state == EVAL);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (go_eval) state_nxt = EVAL;
            EVAL:    if (plast) state_nxt = DONE;
            DONE:    if (result_valid && result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev           <= '0;
            stable_cnt     <= '0;
            settle_cnt     <= '0;
            snap_phase     <= '0;
            snap_weights   <= '0;
            snap_timeout   <= 1'b0;
            acc            <= '0;
            result_valid   <= 1'b0;
            result_score   <= '0;
            result_phase   <= '0;
            result_timeout <= 1'b0;
            best_valid     <= 1'b0;
            best_score     <= '0;
            best_phase     <= '0;
        end else begin
            // Placed first so a best update later in this block overrides it.
            if (clear_best) begin
                best_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        prev       <= phase;
                        stable_cnt <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    stable_cnt <= (phase == prev) ? stable_cnt + 1'b1 : '0;
                    prev       <= phase;
                    if (go_eval) begin
                        snap_phase   <= phase;
                        snap_weights <= weights;
                        snap_timeout <= !stable_hit;
                        acc          <= '0;
                    end
                end
                EVAL: begin
                    acc <= score_final;
                    if (plast) begin
                        result_score   <= score_final;
                        result_phase   <= snap_phase;
                        result_timeout <= snap_timeout;
                        result_valid   <= 1'b1;
                        if (!best_valid || score_final > best_score) begin
                            best_score <= score_final;
                            best_phase <= snap_phase;
                            best_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_energy_monitor.sv
// Directed self-checking bench for ising_energy_monitor (N=6, 3 weight levels,
// STABLE_CYCLES=8, TIMEOUT=32).
module tb_ising_energy_monitor;

    localparam int unsigned SW = 5;

    // Max-cut graph, pair p at bits [2p+1:2p], MSB = pair 14 (EF):
    // EF=10 DF=10 DE=00 CF=10 CE=01 CD=00 BF=10 BE=01 BD=00 BC=00
    // AF=10 AE=00 AD=01 AC=01 AB=00
    localparam logic [29:0] W_MAXCUT = {2'b10, 2'b10, 2'b00, 2'b10, 2'b01,
                                        2'b00, 2'b10, 2'b01, 2'b00, 2'b00,
                                        2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [29:0] W_ALL_POS = 30'h2AAAAAAA;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [29:0]          weights;
    logic [5:0]           phase;
    logic                 start;
    logic                 clear_best;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready;
    logic signed [SW-1:0] result_score;
    logic [5:0]           result_phase;
    logic                 result_timeout;
    logic                 best_valid;
    logic signed [SW-1:0] best_score;
    logic [5:0]           best_phase;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    ising_energy_monitor #(
        .N             (6),
        .NUM_WEIGHTS   (3),
        .STABLE_CYCLES (8),
        .TIMEOUT       (32)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .weights        (weights),
        .phase          (phase),
        .start          (start),
        .clear_best     (clear_best),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_score   (result_score),
        .result_phase   (result_phase),
        .result_timeout (result_timeout),
        .best_valid     (best_valid),
        .best_score     (best_score),
        .best_phase     (best_phase)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and counts edges after the start edge until result_valid.
    // With toggle set, bit0 flips every 4 cycles so the phases never settle.
    task automatic run(input logic [5:0] base, input bit toggle, output int n);
        phase = base;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 300) begin
            if (toggle) phase = base ^ 6'((n / 4) & 1);
            step();
            n++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    initial begin
        weights      = W_MAXCUT;
        phase        = '0;
        start        = 1'b0;
        clear_best   = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_score", result_score, 0);
        chk("rst_phase", result_phase, 0);
        chk("rst_timeout", result_timeout, 0);
        chk("rst_best_valid", best_valid, 0);
        chk("rst_best_score", best_score, 0);
        chk("rst_best_phase", best_phase, 0);
        rstn = 1'b1;
        step();

        // all spins equal: -6 from the J=-1 pairs, +5 from the J=+1 pairs
        run(6'b000000, 1'b0, lat);
        chk("r1_latency", lat, 23);
        chk("r1_score", result_score, -1);
        chk("r1_timeout", result_timeout, 0);
        chk("r1_busy", busy, 0);
        chk("r1_best_valid", best_valid, 1);
        chk("r1_best_score", best_score, -1);
        accept();
        chk("r1_valid_drop", result_valid, 0);

        // max cut assignment: +4 from J=-1 pairs, +1 from J=+1 pairs
        run(6'b101101, 1'b0, lat);
        chk("r2_latency", lat, 23);
        chk("r2_score", result_score, 5);
        chk("r2_phase", result_phase, 6'b101101);
        chk("r2_best_score", best_score, 5);
        chk("r2_best_phase", best_phase, 6'b101101);
        accept();

        run(6'b000000, 1'b0, lat);
        chk("r3_score", result_score, -1);
        chk("r3_best_score", best_score, 5);
        chk("r3_best_phase", best_phase, 6'b101101);
        accept();

        // snapshot at edge 32 sees bit0 flipped: 101100 scores -1
        run(6'b101101, 1'b1, lat);
        chk("to_latency", lat, 47);
        chk("to_timeout", result_timeout, 1);
        chk("to_score", result_score, -1);
        chk("to_phase", result_phase, 6'b101100);
        chk("to_best_score", best_score, 5);

        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            step();
            chk("hold_valid", result_valid, 1);
            chk("hold_busy", busy, 0);
            chk("hold_score", result_score, -1);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        start        = 1'b1;
        step();
        chk("hs_valid", result_valid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_score_kept", result_score, -1);
        chk("hs_timeout_kept", result_timeout, 1);
        result_ready = 1'b0;
        start        = 1'b0;
        step();
        chk("hs_idle", busy, 0);

        // inputs change once EVAL has begun; only the snapshot counts
        phase = 6'b000000;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("snap_busy", busy, 1);
        phase   = 6'b101101;
        weights = W_ALL_POS;
        lat = 8;
        while (!result_valid && lat < 300) begin
            step();
            lat++;
        end
        chk("snap_latency", lat, 23);
        chk("snap_score", result_score, -1);
        chk("snap_phase", result_phase, 6'b000000);
        weights = W_MAXCUT;
        accept();

        phase = 6'b101101;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("mid_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_score", result_score, 0);
        chk("mid_rst_phase", result_phase, 0);
        chk("mid_rst_best_valid", best_valid, 0);
        chk("mid_rst_best_score", best_score, 0);
        chk("mid_rst_best_phase", best_phase, 0);
        step();
        rstn = 1'b1;
        step();
        chk("post_rst_valid", result_valid, 0);

        clear_best = 1'b1;
        run(6'b000000, 1'b0, lat);
        chk("clr_upd_latency", lat, 23);
        chk("clr_upd_best_valid", best_valid, 1);
        chk("clr_upd_best_score", best_score, -1);
        chk("clr_upd_best_phase", best_phase, 6'b000000);
        clear_best = 1'b0;
        accept();
        chk("clr_keep_best_valid", best_valid, 1);
        clear_best = 1'b1;
        step();
        clear_best = 1'b0;
        chk("clr_alone_best_valid", best_valid, 0);
        step();
        chk("clr_alone_stays", best_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ising_energy_monitor.md
Name: ising_energy_monitor

Overview:
Downstream consumer of top_ising. Watches the `phase` vector and waits until the oscillator network has settled. It then snapshots the solution and scores it against the same `weights` bus that programs the array. The result is presented over a valid/ready handshake, and the best solution seen since reset or clear is retained for host readout.

Parameters:
N, 6, number of spins; the last spin is the local-field spin.
NUM_WEIGHTS, 3, number of coupling levels per pair.
STABLE_CYCLES, 8, consecutive unchanged-phase cycles that count as "settled".
TIMEOUT, 1024, maximum SETTLE cycles before forced evaluation.

Derived values (localparams):
- NUM_PAIRS = N*(N-1)/2
- WW = $clog2(NUM_WEIGHTS)
- BIAS = (NUM_WEIGHTS-1)/2
- SW = $clog2(NUM_PAIRS*BIAS+1)+1

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
weights  in  NUM_PAIRS*WW  packed coupling codes, same bus as top_ising
phase  in  N  spin phases from top_ising, synchronous to clk
start  in  1  pulse; begin a settle/evaluate run (honoured only in IDLE)
clear_best  in  1  invalidate the best-solution record
busy  out  1  high in SETTLE and EVAL
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_score  out  SW  signed score of snapshotted phase
result_phase  out  N  snapshotted phase
result_timeout  out  1  run ended by TIMEOUT, not by stability
best_valid  out  1  best record holds a result
best_score  out  SW  signed best score
best_phase  out  N  phase achieving best_score

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE.
  - All outputs go to 0, including best_valid, and all counters go to 0.
  - Reset in any state aborts the run; no partial result is ever presented.
- Weight decode:
  - Pair (i,j) with i<j has index p, enumerated i-major then j ascending: (0,1)=0, (0,2)=1, …, (N-2,N-1)=NUM_PAIRS-1.
  - Code is weights[p*WW +: WW]; coupling J = code − BIAS (default: 00=−1, 01=0, 10=+1).
  - Spin s = phase bit ? +1 : −1.
- Score = Σ J_ij·s_i·s_j, signed SW bits. It cannot overflow by construction. Higher score means lower Ising energy.
- State IDLE:
  - On start: prev ← phase, stable_cnt ← 0, settle_cnt ← 0, state → SETTLE.
- State SETTLE (one edge per cycle):
  - settle_cnt increments every edge.
  - If phase==prev, stable_cnt++; otherwise stable_cnt ← 0. prev ← phase.
  - When stable_cnt reaches STABLE_CYCLES: snapshot phase and weights, timeout flag ← 0, acc ← 0, pair index ← 0, state → EVAL.
  - Otherwise, when settle_cnt reaches TIMEOUT: same transition with timeout flag ← 1.
  - If both conditions occur on the same edge, stability wins (flag 0).
- State EVAL:
  - One pair per cycle: acc += J·s_i·s_j, using the snapshot only. Phase and weights changes are ignored.
  - After pair NUM_PAIRS-1: latch result_score, result_phase and result_timeout; result_valid ← 1; state → DONE.
  - Best update on that same edge: if !best_valid or score > best_score, then best_score and best_phase are loaded and best_valid ← 1.
  - Ties keep the older record.
- State DONE:
  - Outputs are held stable while result_valid && !result_ready.
  - On result_valid && result_ready: result_valid ← 0, state → IDLE. result_* data retain their last values.
- start outside IDLE is ignored, including in the handshake cycle.
- clear_best: best_valid ← 0 on the next edge. If it coincides with a best update, the update wins.
- Latency with constant phase: result_valid rises STABLE_CYCLES+NUM_PAIRS edges after the start edge (23 for defaults).
- busy=1 exactly in SETTLE and EVAL.

Decomposition:
- Shared include (alongside top_ising's):
  - clog2/width localparams
  - NUM_PAIRS/BIAS derivation
  - function pair_index(i,j)
  - state encodings IDLE/SETTLE/EVAL/DONE
- One sub-module, ising_pair_iter:
  - Counter producing (i, j, p) in i-major order.
  - Signals last on p=NUM_PAIRS-1.
  - Restarted by a load strobe.

Test Plan:
- Max-cut graph with defaults (AB, AE, BC, BD, CD, DE = 00; AF, BF, CF, DF, EF = 10; rest 01), phase held 6'b101101, start → result_valid at +23 cycles, result_score=+5, result_timeout=0, best_score=+5.
- Same weights, phase 6'b000000 → score −1. Then a second run with 101101 → best updates to +5. A third run with 000000 → best stays +5.
- Phase toggling bit0 every 4 cycles, TIMEOUT=32 → result_timeout=1, result_valid at 32+15 edges after start.
- Hold result_ready=0 for 10 cycles after valid, pulse start meanwhile → outputs stable, start ignored. Ready=1 → valid drops next edge, state IDLE.
- Change phase and weights during EVAL → score equals snapshot-based value. Assert rstn mid-EVAL → all outputs 0, best_valid=0.
- clear_best coincident with a best update → best_valid=1 with new value. clear_best alone → best_valid=0.
